// File: rtl/lcd_write_engine.sv
// lcd_write_engine: HD44780-class character-LCD driver, 8-bit write-only mode.
// After reset it waits for panel power-up and plays the seven-word init
// sequence. It then accepts one {RS, byte} word per data_ready handshake
// while idle. All panel timing comes from a single down-counter; the panel
// busy flag is never read back.
module lcd_write_engine #(
  parameter int T_POWERUP = 1000000,
  parameter int T_WAKE    = 250000,
  parameter int T_CMD     = 2500,
  parameter int T_CLEAR   = 100000,
  parameter int T_SETUP   = 2,
  parameter int T_E_HIGH  = 13,
  parameter int CNT_W     = 20
) (
  input  logic       clock,
  input  logic       internal_reset,
  input  logic       data_ready,
  input  logic [8:0] rom_data,
  output logic       lcd_busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_SETUP   = 3'd1,
    S_EHIGH   = 3'd2,
    S_HOLD    = 3'd3,
    S_IDLE    = 3'd4
  } state_t;

  // Counter load values: a state entered with N-1 lasts exactly N cycles.
  localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(T_POWERUP - 1);
  localparam logic [CNT_W-1:0] LD_WAKE    = CNT_W'(T_WAKE - 1);
  localparam logic [CNT_W-1:0] LD_CMD     = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR   = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_E_HIGH  = CNT_W'(T_E_HIGH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // Index of the last init entry (seven entries, 0..6).
  localparam logic [2:0] LAST_INIT = 3'd6;
  // Entries below this index are the wake commands that need the long hold.
  localparam logic [2:0] NUM_WAKE  = 3'd2;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic             init_r;
  logic [CNT_W-1:0] hold_load_s;

  // Power-on init table; every entry is a command (RS = 0).
  function automatic logic [7:0] init_byte(input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0:    b = 8'h30;
      3'd1:    b = 8'h30;
      3'd2:    b = 8'h30;
      3'd3:    b = 8'h38;
      3'd4:    b = 8'h0C;
      3'd5:    b = 8'h01;
      3'd6:    b = 8'h06;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long hold.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] b);
    return (rs == 1'b0) && ((b == 8'h01) || (b == 8'h02) || (b == 8'h03));
  endfunction

  // The panel never drives the bus: read/write pin tied to write.
  assign lcd_rw = 1'b0;

  // Pick the post-strobe hold length from the word currently on the pins.
  always_comb begin
    hold_load_s = LD_CMD;
    if (init_r && (idx_r < NUM_WAKE)) begin
      hold_load_s = LD_WAKE;
    end else if (is_slow_cmd(lcd_rs, lcd_data)) begin
      hold_load_s = LD_CLEAR;
    end else begin
      hold_load_s = LD_CMD;
    end
  end

  // Main sequencer: power-up wait, init playback, and write handshake.
  always_ff @(posedge clock or negedge internal_reset) begin
    if (!internal_reset) begin
      state_r  <= S_POWERUP;
      cnt_r    <= LD_POWERUP;
      idx_r    <= 3'd0;
      init_r   <= 1'b1;
      lcd_busy <= 1'b1;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      case (state_r)
        S_POWERUP: begin
          if (cnt_r == CNT_ZERO) begin
            idx_r    <= 3'd0;
            lcd_rs   <= 1'b0;
            lcd_data <= init_byte(3'd0);
            cnt_r    <= LD_SETUP;
            state_r  <= S_SETUP;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        S_SETUP: begin
          if (cnt_r == CNT_ZERO) begin
            lcd_e   <= 1'b1;
            cnt_r   <= LD_E_HIGH;
            state_r <= S_EHIGH;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        S_EHIGH: begin
          if (cnt_r == CNT_ZERO) begin
            lcd_e   <= 1'b0;
            cnt_r   <= hold_load_s;
            state_r <= S_HOLD;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        S_HOLD: begin
          if (cnt_r == CNT_ZERO) begin
            if (init_r && (idx_r < LAST_INIT)) begin
              idx_r    <= idx_r + 3'd1;
              lcd_rs   <= 1'b0;
              lcd_data <= init_byte(idx_r + 3'd1);
              cnt_r    <= LD_SETUP;
              state_r  <= S_SETUP;
            end else begin
              init_r   <= 1'b0;
              lcd_busy <= 1'b0;
              state_r  <= S_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        S_IDLE: begin
          lcd_e <= 1'b0;
          if (data_ready) begin
            lcd_rs   <= rom_data[8];
            lcd_data <= rom_data[7:0];
            lcd_busy <= 1'b1;
            cnt_r    <= LD_SETUP;
            state_r  <= S_SETUP;
          end else begin
            lcd_busy <= 1'b0;
          end
        end

        default: begin
          state_r  <= S_POWERUP;
          cnt_r    <= LD_POWERUP;
          idx_r    <= 3'd0;
          init_r   <= 1'b1;
          lcd_busy <= 1'b1;
          lcd_e    <= 1'b0;
          lcd_rs   <= 1'b0;
          lcd_data <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Testbench for lcd_write_engine: power-on init, table-driven writes,
// mid-write handshake corner cases, reset during the strobe, and a small
// ROM-driven upstream controller.
module tb_lcd_write_engine;

  localparam int T_POWERUP = 100;
  localparam int T_WAKE    = 50;
  localparam int T_CMD     = 10;
  localparam int T_CLEAR   = 40;
  localparam int T_SETUP   = 2;
  localparam int T_E_HIGH  = 4;

  // 100 + 7*(2+4) + 2*50 + 4*10 + 40
  localparam int INIT_BUSY = 322;
  // 2 + 4 + 10 and 2 + 4 + 40
  localparam int LEN_CMD   = 16;
  localparam int LEN_CLEAR = 46;

  logic       clock = 1'b0;
  logic       internal_reset = 1'b0;
  logic       data_ready = 1'b0;
  logic [8:0] rom_data = 9'h000;
  logic       lcd_busy;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  lcd_write_engine #(
    .T_POWERUP(T_POWERUP),
    .T_WAKE   (T_WAKE),
    .T_CMD    (T_CMD),
    .T_CLEAR  (T_CLEAR),
    .T_SETUP  (T_SETUP),
    .T_E_HIGH (T_E_HIGH),
    .CNT_W    (20)
  ) dut (
    .clock         (clock),
    .internal_reset(internal_reset),
    .data_ready    (data_ready),
    .rom_data      (rom_data),
    .lcd_busy      (lcd_busy),
    .lcd_rs        (lcd_rs),
    .lcd_rw        (lcd_rw),
    .lcd_e         (lcd_e),
    .lcd_data      (lcd_data)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // E-pulse monitor: records the word on the pins at each rising E and
  // each pulse width in cycles (sampled on the falling clock edge).
  int         pulses = 0;
  int         cur_w  = 0;
  logic       e_prev = 1'b0;
  logic [8:0] words[$];
  int         widths[$];

  always @(negedge clock) begin
    if (lcd_e === 1'b1 && e_prev !== 1'b1) begin
      pulses++;
      words.push_back({lcd_rs, lcd_data});
      cur_w = 1;
    end else if (lcd_e === 1'b1) begin
      cur_w++;
    end else if (e_prev === 1'b1) begin
      widths.push_back(cur_w);
    end
    e_prev = lcd_e;
  end

  logic [8:0] init_tab [7] = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h00C, 9'h001, 9'h006};

  // Release reset (called on a falling edge) and check the whole init.
  task automatic run_init(input string nm);
    int n;
    n = 0;
    words.delete();
    widths.delete();
    pulses = 0;
    internal_reset = 1'b1;
    while (lcd_busy === 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check({nm, " init_busy_len"}, 32'(n), 32'(INIT_BUSY));
    check({nm, " init_pulses"}, 32'(pulses), 32'd7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("%s init_word%0d", nm, i),
            (words.size() > i) ? 32'(words[i]) : 32'hFFFF, 32'(init_tab[i]));
      check($sformatf("%s init_width%0d", nm, i),
            (widths.size() > i) ? 32'(widths[i]) : 32'd0, 32'(T_E_HIGH));
    end
  endtask

  // One write presented for a single cycle from idle (called on a falling edge).
  task automatic do_write(input logic [8:0] w, input logic exp_rs, input logic [7:0] exp_db,
                          input int exp_len, input string nm);
    int n;
    int p0;
    int first_e;
    n = 0;
    first_e = 0;
    p0 = pulses;
    data_ready = 1'b1;
    rom_data = w;
    @(negedge clock);
    data_ready = 1'b0;
    rom_data = ~w;
    check({nm, " busy_rise"}, 32'(lcd_busy), 32'd1);
    check({nm, " rs"}, 32'(lcd_rs), 32'(exp_rs));
    check({nm, " db"}, 32'(lcd_data), 32'(exp_db));
    while (lcd_busy === 1'b1 && n < 1000) begin
      n++;
      if (lcd_e === 1'b1 && first_e == 0) first_e = n;
      @(negedge clock);
    end
    check({nm, " busy_len"}, 32'(n), 32'(exp_len));
    check({nm, " setup"}, 32'(first_e), 32'(T_SETUP + 1));
    check({nm, " pulses"}, 32'(pulses), 32'(p0 + 1));
    check({nm, " width"}, (widths.size() > 0) ? 32'(widths[$]) : 32'd0, 32'(T_E_HIGH));
    check({nm, " pins_held"}, 32'({lcd_rs, lcd_data}), 32'({exp_rs, exp_db}));
  endtask

  // Wait on a falling edge for busy to go low, bounded.
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (lcd_busy === 1'b1 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 1000) check({nm, " idle_timeout"}, 32'(lcd_busy), 32'd0);
  endtask

  typedef struct {
    logic [8:0] word;
    logic       exp_rs;
    logic [7:0] exp_db;
    int         exp_len;
  } vec_t;

  vec_t vecs[8];
  logic [8:0] rom [16];

  initial begin
    vecs[0] = '{9'h141, 1'b1, 8'h41, LEN_CMD};
    vecs[1] = '{9'h001, 1'b0, 8'h01, LEN_CLEAR};
    vecs[2] = '{9'h002, 1'b0, 8'h02, LEN_CLEAR};
    vecs[3] = '{9'h003, 1'b0, 8'h03, LEN_CLEAR};
    vecs[4] = '{9'h004, 1'b0, 8'h04, LEN_CMD};
    vecs[5] = '{9'h101, 1'b1, 8'h01, LEN_CMD};
    vecs[6] = '{9'h030, 1'b0, 8'h30, LEN_CMD};
    vecs[7] = '{9'h1FF, 1'b1, 8'hFF, LEN_CMD};

    rom = '{9'h080, 9'h148, 9'h165, 9'h16C, 9'h16C, 9'h16F, 9'h120, 9'h14C,
            9'h143, 9'h144, 9'h0C0, 9'h131, 9'h132, 9'h133, 9'h006, 9'h000};

    // Reset values while held in reset.
    repeat (3) @(negedge clock);
    check("rst busy", 32'(lcd_busy), 32'd1);
    check("rst e", 32'(lcd_e), 32'd0);
    check("rst rs", 32'(lcd_rs), 32'd0);
    check("rst rw", 32'(lcd_rw), 32'd0);
    check("rst db", 32'(lcd_data), 32'd0);

    run_init("first");
    check("idle e", 32'(lcd_e), 32'd0);
    check("idle rw", 32'(lcd_rw), 32'd0);

    // Table-driven single writes.
    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].word, vecs[i].exp_rs, vecs[i].exp_db, vecs[i].exp_len,
               $sformatf("vec%0d", i));
    end

    // data_ready pulse and rom_data change while busy are ignored.
    begin
      int p0;
      p0 = pulses;
      data_ready = 1'b1;
      rom_data = 9'h155;
      @(negedge clock);
      data_ready = 1'b0;
      rom_data = 9'h0AA;
      repeat (3) @(negedge clock);
      data_ready = 1'b1;
      @(negedge clock);
      data_ready = 1'b0;
      wait_idle("midwrite");
      repeat (5) @(negedge clock);
      check("midwrite pulses", 32'(pulses), 32'(p0 + 1));
      check("midwrite pins", 32'({lcd_rs, lcd_data}), 32'h155);
      check("midwrite busy", 32'(lcd_busy), 32'd0);
    end

    // data_ready held high through busy falling gives a second identical write.
    begin
      int p0;
      p0 = pulses;
      data_ready = 1'b1;
      rom_data = 9'h177;
      @(negedge clock);
      check("hold first_accept", 32'(lcd_busy), 32'd1);
      wait_idle("hold first");
      check("hold gap_low", 32'(lcd_busy), 32'd0);
      @(negedge clock);
      check("hold second_accept", 32'(lcd_busy), 32'd1);
      data_ready = 1'b0;
      wait_idle("hold second");
      check("hold pulses", 32'(pulses), 32'(p0 + 2));
      check("hold word2", (words.size() > 0) ? 32'(words[$]) : 32'h0, 32'h177);
    end

    // Reset asserted during the E strobe aborts at once; init reruns fully.
    begin
      int n;
      n = 0;
      data_ready = 1'b1;
      rom_data = 9'h148;
      @(negedge clock);
      data_ready = 1'b0;
      while (lcd_e !== 1'b1 && n < 20) begin
        @(negedge clock);
        n++;
      end
      check("ehigh reached", 32'(lcd_e), 32'd1);
      #2 internal_reset = 1'b0;
      #1;
      check("abort e", 32'(lcd_e), 32'd0);
      check("abort busy", 32'(lcd_busy), 32'd1);
      check("abort db", 32'(lcd_data), 32'd0);
      repeat (3) @(negedge clock);
      run_init("rerun");
    end

    // Upstream controller stepping through a 16-word ROM, last word unused.
    begin
      int n;
      words.delete();
      widths.delete();
      pulses = 0;
      for (int a = 0; a < 15; a++) begin
        wait_idle($sformatf("ctrl addr%0d", a));
        data_ready = 1'b1;
        rom_data = rom[a];
        @(negedge clock);
        data_ready = 1'b0;
        rom_data = rom[(a + 1) % 16];
        wait_idle($sformatf("ctrl done%0d", a));
      end
      n = pulses;
      repeat (200) @(negedge clock);
      check("ctrl pulses", 32'(pulses), 32'd15);
      check("ctrl no_more", 32'(pulses), 32'(n));
      check("ctrl busy_idle", 32'(lcd_busy), 32'd0);
      for (int i = 0; i < 15; i++) begin
        check($sformatf("ctrl word%0d", i),
              (words.size() > i) ? 32'(words[i]) : 32'hFFFF, 32'(rom[i]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_write_engine.md
Name: lcd_write_engine

Overview:
- HD44780-class character-LCD driver in 8-bit, write-only mode.
- Sits directly downstream of the ROM-sequencing controller. It consumes `data_ready` plus the 9-bit ROM word (RS and byte).
- Drives the panel pins and produces the `lcd_busy` flag that the controller watches for edges.
- After reset it runs the panel's power-on initialisation on its own, then accepts one write per handshake.

Parameters:
- T_POWERUP, 1000000: cycles of idle wait after reset before the first init command (20 ms at 50 MHz).
- T_WAKE, 250000: hold after each of the first two 0x30 wake commands (5 ms).
- T_CMD, 2500: hold after ordinary commands and data writes (50 us).
- T_CLEAR, 100000: hold after clear or return-home (2 ms).
- T_SETUP, 2: cycles RS/DB are stable before E rises.
- T_E_HIGH, 13: cycles E is high (≥250 ns).
- CNT_W, 20: width of the delay counter. Must hold the largest T_* minus 1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- internal_reset  in  1  asynchronous, active-low reset.
- data_ready  in  1  level. High while idle means "write rom_data".
- rom_data  in  9  bit 8 = RS (0 = command, 1 = character), bits 7:0 = byte.
- lcd_busy  out  1  high from reset through init, and during every write.
- lcd_rs  out  1  register-select pin.
- lcd_rw  out  1  read/write pin. Constant 0.
- lcd_e  out  1  enable strobe.
- lcd_data  out  8  DB7..DB0.

Behaviour:
- Reset (internal_reset low, asynchronous):
  - State = S_POWERUP, counter = T_POWERUP-1, init index = 0.
  - lcd_busy = 1, lcd_e = 0, lcd_rs = 0, lcd_rw = 0, lcd_data = 0x00.
  - Reset mid-write aborts immediately (E drops at once) and the full init reruns.
- Delay counter: each timed state is entered with the counter at N-1 and decrements once per cycle. The state exits on the edge where the counter is 0, so every state lasts exactly N cycles.
- States:
  - S_POWERUP: waits T_POWERUP. On exit, loads init entry 0 onto lcd_rs/lcd_data and goes to S_SETUP.
  - S_SETUP: E = 0 for T_SETUP cycles, then S_EHIGH.
  - S_EHIGH: E = 1 for T_E_HIGH cycles, then S_HOLD.
  - S_HOLD: E = 0, RS/DB held. Duration is selected by the latched word:
    - init entries 0 and 1: T_WAKE;
    - RS = 0 with byte 0x01, 0x02 or 0x03: T_CLEAR;
    - everything else: T_CMD.
  - S_HOLD exit during init with index < 6: index++, load the next entry, go to S_SETUP.
  - S_HOLD exit otherwise: go to S_IDLE and set lcd_busy to 0 on that same edge.
  - S_IDLE: lcd_busy = 0, E = 0, pins hold the last word. If data_ready = 1 at a rising edge:
    - latch rom_data[8] into lcd_rs and rom_data[7:0] into lcd_data;
    - set lcd_busy to 1;
    - go to S_SETUP.
    - lcd_busy is high from the next cycle. Acceptance latency is 1 edge.
- Init table (all RS = 0), in order: 0x30, 0x30, 0x30, 0x38, 0x0C, 0x01, 0x06.
- Init timing: total busy from reset release = T_POWERUP + 7·(T_SETUP+T_E_HIGH) + 2·T_WAKE + 4·T_CMD + T_CLEAR.
- Write timing: busy duration per accepted write = T_SETUP + T_E_HIGH + hold.
- Handshake with upstream:
  - data_ready is ignored in every state except S_IDLE. There is no buffering, so words presented while busy are never captured.
  - data_ready still high in S_IDLE after a write completes is a new request, and is accepted again.
  - data_ready rising on the same edge that busy falls is sampled on the following edge.
- rom_data is sampled only on the acceptance edge. Upstream may change address and data while busy.
- lcd_rw is tied 0. The busy flag is never read back from the panel; all timing is by counter.

Test Plan:
- Sim parameters for all tests: T_POWERUP=100, T_WAKE=50, T_CMD=10, T_CLEAR=40, T_SETUP=2, T_E_HIGH=4.
- Reset, then release → during reset all outputs at their reset values with busy = 1. After release:
  - exactly 7 E pulses, each 4 cycles wide, with DB = 30, 30, 30, 38, 0C, 01, 06;
  - lcd_busy falls 322 cycles after release.
- Idle, data_ready = 1 for one cycle with rom_data = 0x141 → busy high on the next cycle, rs = 1, DB = 0x41, one 4-cycle E pulse after 2 setup cycles, busy low after 16 cycles.
- Write rom_data = 0x001 (clear) → busy lasts 2+4+40 = 46 cycles.
- data_ready pulsed and rom_data changed mid-write → no extra E pulse, pins unchanged. Holding data_ready high through busy-fall → second identical write accepted on the next edge.
- Reset asserted during S_EHIGH → lcd_e 0 immediately and busy = 1. Release → full 322-cycle init repeats.
- Integration with the upstream controller and a 16-word ROM → 15 writes, in address order, then busy stays 0 and no further E pulses.
